swap_cmd_issuer: RTL and testbench

//   Initiator side of the swap interface.
//   - Accepts swap requests (address pair) over a valid/ready port and queues them in a small FIFO.
//   - Drives address_A/address_B/swap of swap_reg_file one request at a time.
//   - Holds the addresses stable for the whole swap window, then signals completion.
//   - While a swap is in flight, the host must not issue reg-file writes.

---
 rtl/swap_cmd_issuer.sv | 149 ++++++++++++++
 tb/tb_swap_cmd_issuer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/swap_cmd_issuer.sv
// swap_cmd_issuer: initiator side of the swap interface.
// Queues address-pair requests in a small FIFO and drives a swap_reg_file
// one request at a time, holding the addresses stable for the whole swap
// window and pulsing done when each request retires.
module swap_cmd_issuer #(
   parameter int ADDR_WIDTH  = 7,
   parameter int FIFO_DEPTH  = 4,
   parameter int SWAP_CYCLES = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDR_WIDTH-1:0]         req_addr_a,
   input  logic [ADDR_WIDTH-1:0]         req_addr_b,
   output logic [ADDR_WIDTH-1:0]         address_A,
   output logic [ADDR_WIDTH-1:0]         address_B,
   output logic                          swap,
   output logic                          busy,
   output logic                          done,
   output logic                          skipped,
   output logic [$clog2(FIFO_DEPTH):0]   q_count,
   output logic [15:0]                   swap_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(SWAP_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [ADDR_WIDTH-1:0] fifo_a_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_b_mem [FIFO_DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]           cnt_q, cnt_d;
   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic [15:0]           swap_cnt_q, swap_cnt_d;
   logic                  swap_q, swap_d, busy_q, busy_d;
   logic                  done_q, done_d, skipped_q, skipped_d;
   logic                  push, pop;

   assign req_ready  = (cnt_q != (PW+1)'(FIFO_DEPTH));
   assign push       = req_valid && req_ready;
   assign pop        = (state_q == S_IDLE) && (cnt_q != '0);
   assign address_A  = addr_a_q;
   assign address_B  = addr_b_q;
   assign swap       = swap_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign skipped    = skipped_q;
   assign q_count    = cnt_q;
   assign swap_count = swap_cnt_q;

   // FIFO occupancy and pointers; simultaneous push/pop leaves the count unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   // Request storage; contents need no reset since the count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a_mem[wr_ptr_q] <= req_addr_a;
         fifo_b_mem[wr_ptr_q] <= req_addr_b;
      end
   end

   // Swap sequencer: pop, check for a trivial swap, pulse, wait out the target, retire
   always_comb begin
      state_d    = state_q;
      addr_a_d   = addr_a_q;
      addr_b_d   = addr_b_q;
      wcnt_d     = wcnt_q;
      swap_cnt_d = swap_cnt_q;
      case (state_q)
         S_IDLE: if (pop) begin
            addr_a_d = fifo_a_mem[rd_ptr_q];
            addr_b_d = fifo_b_mem[rd_ptr_q];
            state_d  = S_LOAD;
         end
         S_LOAD: begin
            if (addr_a_q == addr_b_q) begin
               state_d = S_DONE;
            end else begin
               // count at the same edge the pulse rises so they are seen together
               swap_cnt_d = swap_cnt_q + 16'd1;
               wcnt_d     = '0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == CW'(SWAP_CYCLES - 1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the next state so they come straight off flops
   always_comb begin
      swap_d    = (state_d == S_ISSUE);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      skipped_d = (state_q == S_LOAD) && (state_d == S_DONE);
   end

   // State and control registers; reset abandons any swap in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         state_q    <= S_IDLE;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         wcnt_q     <= '0;
         swap_cnt_q <= '0;
         swap_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         skipped_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         addr_a_q   <= addr_a_d;
         addr_b_q   <= addr_b_d;
         wcnt_q     <= wcnt_d;
         swap_cnt_q <= swap_cnt_d;
         swap_q     <= swap_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         skipped_q  <= skipped_d;
      end
   end
endmodule

// File: tb/tb_swap_cmd_issuer.sv
// Bench for swap_cmd_issuer: directed scenarios plus random traffic, checked
// every cycle against a request-queue / job-timeline reference model.
module tb_swap_cmd_issuer;
   localparam int AW    = 7;
   localparam int DEPTH = 4;
   localparam int SC    = 3;
   localparam int QW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr_a, req_addr_b, address_A, address_B;
   logic          swap, busy, done, skipped;
   logic [QW-1:0] q_count;
   logic [15:0]   swap_count;

   swap_cmd_issuer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .SWAP_CYCLES(SC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
      .address_A(address_A), .address_B(address_B), .swap(swap), .busy(busy),
      .done(done), .skipped(skipped), .q_count(q_count), .swap_count(swap_count));

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0, cyc_n = 0;

   // reference model: pending queue plus the job currently being served,
   // tracked as an offset from its pop (0 = first busy cycle)
   logic [AW-1:0] qa[$], qb[$];
   bit            jact, jskip;
   int            joff, mcnt;
   logic [AW-1:0] ma, mb;
   logic [7:0]    mem [0:(1<<AW)-1];
   int            last_swap = -1;
   int            gaps[$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      qa.delete(); qb.delete();
      jact = 0; jskip = 0; joff = 0; mcnt = 0; ma = '0; mb = '0;
   endtask

   // compare this cycle's outputs with the model; also act as the target memory
   task automatic cmp();
      int len;
      bit e_swap, e_done;
      logic [7:0] t;
      len    = jskip ? 2 : SC + 3;
      e_swap = jact && !jskip && joff == 1;
      e_done = jact && joff == len - 1;
      chk("q_count",    32'(q_count),    32'(qa.size()));
      chk("req_ready",  32'(req_ready),  32'(qa.size() < DEPTH));
      chk("busy",       32'(busy),       32'(jact));
      chk("swap",       32'(swap),       32'(e_swap));
      chk("done",       32'(done),       32'(e_done));
      chk("skipped",    32'(skipped),    32'(e_done && jskip));
      chk("address_A",  32'(address_A),  32'(ma));
      chk("address_B",  32'(address_B),  32'(mb));
      chk("swap_count", 32'(swap_count), 32'(mcnt));
      if (done && !skipped) chk("swap_to_done", 32'(cyc_n - last_swap), 32'(SC + 1));
      if (swap) begin
         t = mem[address_A]; mem[address_A] = mem[address_B]; mem[address_B] = t;
         if (last_swap >= 0) gaps.push_back(cyc_n - last_swap);
         last_swap = cyc_n;
      end
   endtask

   // advance the model across one rising edge given this cycle's inputs
   task automatic step(bit v, logic [AW-1:0] a, logic [AW-1:0] b, output bit acc);
      int len;
      bit pop;
      len = jskip ? 2 : SC + 3;
      pop = !jact && qa.size() != 0;
      acc = v && qa.size() < DEPTH;
      if (jact) begin
         if (joff == len - 1) jact = 0;
         else begin
            joff++;
            if (joff == 1 && !jskip) mcnt = (mcnt + 1) & 16'hFFFF;
         end
      end
      if (pop) begin
         ma = qa.pop_front(); mb = qb.pop_front();
         jact = 1; joff = 0; jskip = (ma == mb);
      end
      if (acc) begin qa.push_back(a); qb.push_back(b); end
   endtask

   task automatic tick(bit v, logic [AW-1:0] a, logic [AW-1:0] b, output bit acc);
      cmp();
      req_valid = v; req_addr_a = a; req_addr_b = b;
      step(v, a, b, acc);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic send(logic [AW-1:0] a, logic [AW-1:0] b);
      bit acc;
      acc = 0;
      for (int k = 0; k < 40 && !acc; k++) tick(1'b1, a, b, acc);
      chk("accept", 32'(acc), 32'd1);
   endtask

   task automatic idle(int n);
      bit acc;
      for (int k = 0; k < n; k++) tick(1'b0, '0, '0, acc);
   endtask

   initial begin
      bit acc, pend;
      logic [AW-1:0] ra, rb;
      reset = 1'b1; req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      cmp();
      reset = 1'b0;

      // single request, then check the memory contents were exchanged
      mem[5] = 8'hAA; mem[9] = 8'h55;
      idle(2);
      send(7'd5, 7'd9);
      idle(10);
      chk("mem5", 32'(mem[5]), 32'h55);
      chk("mem9", 32'(mem[9]), 32'hAA);

      // trivial swap is retired without a pulse
      send(7'h3F, 7'h3F);
      idle(6);

      // burst of six with valid held; queue fills and refuses while full
      last_swap = -1; gaps.delete();
      for (int i = 0; i < 6; i++) send(AW'(i + 1), AW'(i + 17));
      idle(50);
      chk("burst_gaps", 32'(gaps.size()), 32'd5);
      foreach (gaps[i]) chk("burst_gap", 32'(gaps[i]), 32'(SC + 4));

      // reset in the middle of a wait with two requests queued
      send(7'd10, 7'd20); send(7'd30, 7'd40); send(7'd50, 7'd60);
      for (int k = 0; k < 20 && !(jact && joff == 2); k++) tick(1'b0, '0, '0, acc);
      chk("reach_wait", 32'(jact && joff == 2 && qa.size() == 2), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rst_q_count", 32'(q_count), 32'd0);
      chk("rst_ready",   32'(req_ready), 32'd1);
      chk("rst_busy",    32'(busy), 32'd0);
      chk("rst_swap",    32'(swap), 32'd0);
      chk("rst_done",    32'(done), 32'd0);
      chk("rst_addr",    32'({address_A, address_B}), 32'd0);
      chk("rst_count",   32'(swap_count), 32'd0);
      model_reset();
      @(negedge clk);
      cyc_n++;
      reset = 1'b0;
      idle(20);

      // random traffic; the requester holds a request until it is taken
      pend = 0; ra = '0; rb = '0;
      for (int i = 0; i < 600; i++) begin
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1;
            ra = AW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom);
         end
         tick(pend, ra, rb, acc);
         if (acc) pend = 0;
      end
      idle(60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
